xex_tweak_unit: RTL and testbench
=================================

Name: xex_tweak_unit

Overview:
- Datapath companion to the XEX controller.
- Holds the encrypted tweak T and applies pre-whitening (plaintext XOR T) to each block entering the AES core.
- Advances T by multiplication by alpha in GF(2^128) after every accepted block.
- Queues each block's tweak so post-whitening (AES output XOR same T) stays correct while several blocks are in flight in the core.

Parameters:
- DEPTH, 4, maximum number of in-flight blocks; tweak queue entries (power of 2, >=2).
- PTR_W, 2, pointer width = log2(DEPTH).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- tk_ld  in  1  load encrypted tweak (driven by controller tk_ud)
- tk_in  in  128  encrypted tweak from AES output
- flush  in  1  drop all queued tweaks (controller returning to idle)
- blk_in_valid  in  1  plaintext/ciphertext block offered (controller d_valid while d_tk=1)
- blk_in  in  128  input block
- in_rdy  out  1  unit can accept a block this cycle
- aes_in  out  128  whitened block to AES core
- aes_in_valid  out  1  aes_in valid, one-cycle pulse
- aes_out_valid  in  1  AES core result valid (aes_rdy)
- aes_out  in  128  AES core result
- data_out  out  128  post-whitened result
- out_valid  out  1  data_out valid, one-cycle pulse
- tweak  out  128  current T (debug/observation)
- err  out  1  sticky: queue overflow or underflow

Behaviour:
- Reset (rst=1 at clock edge): T=0, queue empty (wr_ptr=rd_ptr=0, count=0), aes_in=0, aes_in_valid=0, data_out=0, out_valid=0, err=0. Reset mid-operation discards all in-flight tweaks; later aes_out_valid pulses are underflows.
- in_rdy = (count<DEPTH) && !tk_ld && !flush (combinational).
- Alpha multiply: T' = {T[126:0],1'b0} XOR (T[127] ? 128'h87 : 0).
- Priority per cycle: rst > tk_ld > flush > normal.
- tk_ld=1: T<=tk_in, queue cleared (count=0); any block offered that cycle is not accepted; aes_out_valid that cycle is ignored with no err.
- flush=1 (tk_ld=0): queue cleared; T unchanged; no accept, no pop, no err.
- Accept: blk_in_valid && in_rdy.
  - Next edge: aes_in <= blk_in XOR T, aes_in_valid <= 1.
  - Current T pushed at wr_ptr; wr_ptr++ (wraps mod DEPTH); T <= T'.
  - Latency in to aes_in: 1 cycle.
- blk_in_valid while count==DEPTH (and no tk_ld/flush): block dropped, err<=1, T unchanged.
- Pop: aes_out_valid && count>0 (no tk_ld/flush).
  - Next edge: data_out <= aes_out XOR queue[rd_ptr], out_valid <= 1; rd_ptr++ (wraps).
  - Latency aes_out to data_out: 1 cycle.
- aes_out_valid with count==0: err<=1, out_valid stays 0, data_out holds.
- Simultaneous accept and pop: both happen; count unchanged.
  - At count==DEPTH, a push in the same cycle as a pop is still refused (in_rdy uses the registered count).
  - At count==0, a simultaneous pop is an underflow; the pushed entry is not bypassed.
- aes_in_valid and out_valid are 0 in every cycle without a new accept/pop; aes_in/data_out hold their last values.
- err clears only on rst.
- Tweak order is strictly FIFO; the AES core returns results in issue order.

Test Plan:
- Reset then idle: all outputs 0, in_rdy=1, err=0 → any aes_out_valid pulse sets err=1, out_valid stays 0.
- Alpha carry: tk_ld with tk_in=128'h80000000_00000000_00000000_00000001, then blk_in=0 accepted:
  - Next cycle aes_in=128'h80000000_00000000_00000000_00000001, aes_in_valid=1.
  - tweak=128'h00000000_00000000_00000000_00000085.
- Round trip: after load T0=128'h1, accept blocks 128'hA, 128'hB on consecutive cycles → aes_in 128'hB then 128'h9 (T1=2).
  - Then aes_out_valid with aes_out=128'hF0, 128'hF0 → data_out 128'hF1 then 128'hF2, out_valid one cycle each.
- Full queue: DEPTH=4, accept 4 blocks with no pops → in_rdy=0; 5th blk_in_valid sets err=1, T still T0*alpha^4.
  - One pop restores in_rdy=1 the next cycle.
- Simultaneous push/pop at count=2 over 10 cycles → count stays 2, every data_out = aes_out XOR tweak issued two blocks earlier, no err.
- tk_ld asserted together with blk_in_valid and queue count=3 → block not accepted, count=0, tweak=tk_in, err unchanged.
  - flush with count=2 → count=0, tweak unchanged.

Source files
------------

// File: rtl/xex_tweak_if.sv
// Bus between the XEX controller and the tweak unit: tweak load, block intake,
// AES core handshake and post-whitened result.
interface xex_tweak_if;
  logic         tk_ld;
  logic [127:0] tk_in;
  logic         flush;
  logic         blk_in_valid;
  logic [127:0] blk_in;
  logic         in_rdy;
  logic [127:0] aes_in;
  logic         aes_in_valid;
  logic         aes_out_valid;
  logic [127:0] aes_out;
  logic [127:0] data_out;
  logic         out_valid;
  logic [127:0] tweak;
  logic         err;

  modport master (
    output tk_ld, tk_in, flush, blk_in_valid, blk_in, aes_out_valid, aes_out,
    input  in_rdy, aes_in, aes_in_valid, data_out, out_valid, tweak, err
  );

  modport slave (
    input  tk_ld, tk_in, flush, blk_in_valid, blk_in, aes_out_valid, aes_out,
    output in_rdy, aes_in, aes_in_valid, data_out, out_valid, tweak, err
  );
endinterface

// File: rtl/xex_tweak_unit.sv
// XEX tweak datapath: pre-whitens blocks with T, advances T by alpha, and
// remembers each issued tweak in a FIFO so AES results are post-whitened with it.
module xex_tweak_unit #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input logic       clk,
  input logic       rst,
  xex_tweak_if.slave bus
);

  localparam logic [PTR_W:0]   FULL_C   = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Multiply by x in GF(2^128) reduced by x^128 + x^7 + x^2 + x + 1.
  function automatic logic [127:0] gf_alpha(input logic [127:0] t);
    return {t[126:0], 1'b0} ^ (t[127] ? 128'h87 : 128'h0);
  endfunction

  logic [127:0]   tweak_r;
  logic [127:0]   q_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0] count_r;
  logic [127:0]   aes_in_r;
  logic           aes_in_valid_r;
  logic [127:0]   data_out_r;
  logic           out_valid_r;
  logic           err_r;

  logic           ctl_busy_s;
  logic           in_rdy_s;
  logic           push_s;
  logic           pop_s;
  logic           ovf_s;
  logic           unf_s;

  // Handshake decode; tk_ld and flush suppress every queue operation.
  always_comb begin
    ctl_busy_s = bus.tk_ld | bus.flush;
    in_rdy_s   = (count_r < FULL_C) && !ctl_busy_s;
    push_s     = bus.blk_in_valid && in_rdy_s;
    pop_s      = bus.aes_out_valid && (count_r != '0) && !ctl_busy_s;
    ovf_s      = bus.blk_in_valid && (count_r == FULL_C) && !ctl_busy_s;
    unf_s      = bus.aes_out_valid && (count_r == '0) && !ctl_busy_s;
  end

  // Tweak register, queue pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tweak_r        <= 128'h0;
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      count_r        <= '0;
      aes_in_r       <= 128'h0;
      aes_in_valid_r <= 1'b0;
      data_out_r     <= 128'h0;
      out_valid_r    <= 1'b0;
      err_r          <= 1'b0;
    end else if (bus.tk_ld) begin
      tweak_r        <= bus.tk_in;
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      count_r        <= '0;
      aes_in_valid_r <= 1'b0;
      out_valid_r    <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      count_r        <= '0;
      aes_in_valid_r <= 1'b0;
      out_valid_r    <= 1'b0;
    end else begin
      aes_in_valid_r <= push_s;
      out_valid_r    <= pop_s;
      if (push_s) begin
        aes_in_r <= bus.blk_in ^ tweak_r;
        tweak_r  <= gf_alpha(tweak_r);
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        data_out_r <= bus.aes_out ^ q_r[rd_ptr_r];
        rd_ptr_r   <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (ovf_s || unf_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Tweak storage; contents are only meaningful below count_r, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_r[wr_ptr_r] <= tweak_r;
    end
  end

  assign bus.in_rdy       = in_rdy_s;
  assign bus.aes_in       = aes_in_r;
  assign bus.aes_in_valid = aes_in_valid_r;
  assign bus.data_out     = data_out_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.tweak        = tweak_r;
  assign bus.err          = err_r;

endmodule

// File: tb/tb_xex_tweak_unit.sv
// Self-checking bench for xex_tweak_unit: queue-based reference model checked
// every cycle, plus directed literal expectations from the test plan.
module tb_xex_tweak_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xex_tweak_if bus();
  xex_tweak_unit #(.DEPTH(4), .PTR_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // reference model state
  logic [127:0] m_t;
  logic [127:0] m_q[$];
  logic         m_err;
  logic         m_aiv, m_ov;
  logic [127:0] m_ai, m_do;

  function automatic logic [127:0] mul_alpha(input logic [127:0] t);
    return (t << 1) ^ (t[127] ? 128'h87 : 128'h0);
  endfunction

  function automatic logic [127:0] alpha_pow(input logic [127:0] t, input int n);
    logic [127:0] r = t;
    for (int i = 0; i < n; i++) r = mul_alpha(r);
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin : model
    bit acc, pop;
    if (rst) begin
      m_t = 128'h0; m_q.delete(); m_err = 1'b0;
      m_aiv = 1'b0; m_ov = 1'b0; m_ai = 128'h0; m_do = 128'h0;
    end else if (bus.tk_ld) begin
      m_t = bus.tk_in; m_q.delete(); m_aiv = 1'b0; m_ov = 1'b0;
    end else if (bus.flush) begin
      m_q.delete(); m_aiv = 1'b0; m_ov = 1'b0;
    end else begin
      acc = bus.blk_in_valid && (m_q.size() < 4);
      pop = bus.aes_out_valid && (m_q.size() > 0);
      if (bus.blk_in_valid && !acc) m_err = 1'b1;
      if (bus.aes_out_valid && !pop) m_err = 1'b1;
      m_aiv = acc;
      m_ov  = pop;
      if (pop) m_do = bus.aes_out ^ m_q.pop_front();
      if (acc) begin
        m_ai = bus.blk_in ^ m_t;
        m_q.push_back(m_t);
        m_t = mul_alpha(m_t);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("aes_in_valid", bus.aes_in_valid, m_aiv);
      chk("aes_in", bus.aes_in, m_ai);
      chk("out_valid", bus.out_valid, m_ov);
      chk("data_out", bus.data_out, m_do);
      chk("tweak", bus.tweak, m_t);
      chk("err", bus.err, m_err);
      chk("in_rdy", bus.in_rdy, (m_q.size() < 4) && !bus.tk_ld && !bus.flush);
    end
  end

  task automatic step(input logic l, input logic [127:0] ti, input logic f,
                      input logic bv, input logic [127:0] b,
                      input logic av, input logic [127:0] a);
    bus.tk_ld = l; bus.tk_in = ti; bus.flush = f;
    bus.blk_in_valid = bv; bus.blk_in = b;
    bus.aes_out_valid = av; bus.aes_out = a;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 128'h0, 1'b0, 1'b0, 128'h0, 1'b0, 128'h0);
  endtask

  task automatic push(input logic [127:0] b);
    step(1'b0, 128'h0, 1'b0, 1'b1, b, 1'b0, 128'h0);
  endtask

  task automatic pop(input logic [127:0] a);
    step(1'b0, 128'h0, 1'b0, 1'b0, 128'h0, 1'b1, a);
  endtask

  task automatic load(input logic [127:0] t);
    step(1'b1, t, 1'b0, 1'b0, 128'h0, 1'b0, 128'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
  endtask

  initial begin
    logic [127:0] t0, ao, tw[16];
    do_reset();
    chk_en = 1'b1;

    // reset state, then underflow from idle
    chk("rst_aes_in", bus.aes_in, 128'h0);
    chk("rst_data_out", bus.data_out, 128'h0);
    chk("rst_tweak", bus.tweak, 128'h0);
    chk("rst_in_rdy", bus.in_rdy, 128'h1);
    chk("rst_err", bus.err, 128'h0);
    pop(128'h1234);
    chk("unf_err", bus.err, 128'h1);
    chk("unf_out_valid", bus.out_valid, 128'h0);
    do_reset();

    // alpha carry
    load(128'h80000000_00000000_00000000_00000001);
    push(128'h0);
    chk("carry_aes_in", bus.aes_in, 128'h80000000_00000000_00000000_00000001);
    chk("carry_aiv", bus.aes_in_valid, 128'h1);
    chk("carry_tweak", bus.tweak, 128'h00000000_00000000_00000000_00000085);
    step(1'b0, 128'h0, 1'b1, 1'b0, 128'h0, 1'b0, 128'h0);

    // round trip
    load(128'h1);
    push(128'hA);
    chk("rt_aes_in0", bus.aes_in, 128'hB);
    push(128'hB);
    chk("rt_aes_in1", bus.aes_in, 128'h9);
    chk("rt_tweak", bus.tweak, 128'h4);
    pop(128'hF0);
    chk("rt_out0", bus.data_out, 128'hF1);
    chk("rt_ov0", bus.out_valid, 128'h1);
    pop(128'hF0);
    chk("rt_out1", bus.data_out, 128'hF2);
    idle();
    chk("rt_ov_low", bus.out_valid, 128'h0);

    // full queue
    load(128'h1);
    for (int i = 0; i < 4; i++) push(rnd128());
    idle();
    chk("full_in_rdy", bus.in_rdy, 128'h0);
    push(128'h55);
    chk("full_err", bus.err, 128'h1);
    chk("full_tweak", bus.tweak, 128'h10);
    chk("full_aiv", bus.aes_in_valid, 128'h0);
    pop(128'h77);
    chk("full_pop_data", bus.data_out, 128'h76);
    chk("full_in_rdy_back", bus.in_rdy, 128'h1);
    do_reset();

    // simultaneous push/pop at count 2
    t0 = rnd128();
    for (int i = 0; i < 16; i++) tw[i] = alpha_pow(t0, i);
    load(t0);
    push(rnd128());
    push(rnd128());
    for (int k = 2; k < 12; k++) begin
      ao = rnd128();
      step(1'b0, 128'h0, 1'b0, 1'b1, rnd128(), 1'b1, ao);
      chk("pp_data", bus.data_out, ao ^ tw[k-2]);
      chk("pp_ov", bus.out_valid, 128'h1);
    end
    chk("pp_err", bus.err, 128'h0);
    chk("pp_tweak", bus.tweak, tw[12]);

    // tk_ld beats a block offer at count 3, then flush at count 2
    load(128'h1);
    for (int i = 0; i < 3; i++) push(rnd128());
    t0 = rnd128();
    step(1'b1, t0, 1'b0, 1'b1, rnd128(), 1'b0, 128'h0);
    chk("ld_tweak", bus.tweak, t0);
    chk("ld_aiv", bus.aes_in_valid, 128'h0);
    chk("ld_err", bus.err, 128'h0);
    push(rnd128());
    push(rnd128());
    step(1'b0, 128'h0, 1'b1, 1'b0, 128'h0, 1'b0, 128'h0);
    chk("fl_tweak", bus.tweak, alpha_pow(t0, 2));
    pop(rnd128());
    chk("fl_empty_err", bus.err, 128'h1);
    chk("fl_empty_ov", bus.out_valid, 128'h0);
    do_reset();
    load(rnd128());

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r == 0) do_reset();
      else step(r < 3, rnd128(), (r >= 3) && (r < 6),
                1'($urandom_range(0, 1)), rnd128(),
                1'($urandom_range(0, 1)), rnd128());
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
